fft_power_streamer: RTL and testbench

- Source end of the mel filterbank bin stream.
- Accepts complex FFT output samples (one per valid cycle, natural order, last-flagged) and computes |X|^2 = re^2 + im^2.
- Emits the lower KEEP_BINS bins as a (power_out, k_out) stream that drives every triangular_filter_N instance in parallel.
- Tracks frame alignment, discards the mirrored upper half, and flags malformed frames.

---
 rtl/mel_pkg.sv | 12 +
 rtl/fft_power_streamer_if.sv | 22 ++
 rtl/fft_power_streamer_complex_mag_sq.sv | 34 +++
 rtl/fft_power_streamer.sv | 74 +++++++
 tb/tb_fft_power_streamer.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/mel_pkg.sv
// mel_pkg: shared constants, bin/power types and stream state for the mel filterbank front end
package mel_pkg;
   localparam int FFT_SIZE    = 1024;
   localparam int NUM_BINS    = 512;
   localparam int NUM_FILTERS = 32;
   localparam int IN_WIDTH    = 16;
   localparam int POWER_WIDTH = 32;
   localparam int K_WIDTH     = 9;
   typedef logic [POWER_WIDTH-1:0] power_t;
   typedef logic [K_WIDTH-1:0] bin_idx_t;
   typedef enum logic {UNSYNCED, STREAM} state_t;
endpackage

// File: rtl/fft_power_streamer_if.sv
// fft_power_streamer_if: complex FFT sample stream in, power bin stream out
interface fft_power_streamer_if;
   import mel_pkg::*;
   logic                       fft_valid_in;
   logic                       fft_last_in;
   logic signed [IN_WIDTH-1:0] fft_re_in;
   logic signed [IN_WIDTH-1:0] fft_im_in;
   power_t                     power_out;
   bin_idx_t                   k_out;
   logic                       power_valid_out;
   logic                       frame_done_out;
   logic                       frame_error_out;
   logic                       synced_out;
   modport master (
      output fft_valid_in, fft_last_in, fft_re_in, fft_im_in,
      input  power_out, k_out, power_valid_out, frame_done_out, frame_error_out, synced_out
   );
   modport slave (
      input  fft_valid_in, fft_last_in, fft_re_in, fft_im_in,
      output power_out, k_out, power_valid_out, frame_done_out, frame_error_out, synced_out
   );
endinterface

// File: rtl/fft_power_streamer_complex_mag_sq.sv
// complex_mag_sq: two-stage re^2+im^2 with valid sideband; power is zero whenever valid is low
module complex_mag_sq
   import mel_pkg::*;
#(
   parameter int IN_WIDTH    = mel_pkg::IN_WIDTH,
   parameter int POWER_WIDTH = mel_pkg::POWER_WIDTH
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   in_valid,
   input  logic signed [IN_WIDTH-1:0] re,
   input  logic signed [IN_WIDTH-1:0] im,
   output logic                   out_valid,
   output logic [POWER_WIDTH-1:0] power
);
   localparam int PW = 2 * IN_WIDTH;
   logic signed [PW-1:0] re_x, im_x, re_sq, im_sq;
   logic v2;
   assign re_x = PW'(re);
   assign im_x = PW'(im);
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         v2        <= 1'b0;
         out_valid <= 1'b0;
         power     <= '0;
      end else begin
         v2        <= in_valid;
         re_sq     <= re_x * re_x;
         im_sq     <= im_x * im_x;
         out_valid <= v2;
         power     <= v2 ? POWER_WIDTH'($unsigned(re_sq)) + POWER_WIDTH'($unsigned(im_sq)) : '0;
      end
   end
endmodule

// File: rtl/fft_power_streamer.sv
// fft_power_streamer: frame-aligns FFT samples and streams |X|^2 of the lower KEEP_BINS bins
// with a fixed 3-cycle latency; the mirrored upper half is dropped and misaligned frames are flagged.
module fft_power_streamer
   import mel_pkg::*;
#(
   parameter int FFT_SIZE    = mel_pkg::FFT_SIZE,
   parameter int KEEP_BINS   = mel_pkg::NUM_BINS,
   parameter int IN_WIDTH    = mel_pkg::IN_WIDTH,
   parameter int POWER_WIDTH = mel_pkg::POWER_WIDTH,
   parameter int K_WIDTH     = mel_pkg::K_WIDTH
) (
   input logic                clk_in,
   input logic                rst_in,
   fft_power_streamer_if.slave bus
);
   localparam int CNT_W = $clog2(FFT_SIZE);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FFT_SIZE - 1);
   localparam logic [CNT_W:0]     KEEP_LIM = (CNT_W + 1)'(KEEP_BINS);
   localparam logic [K_WIDTH-1:0] K_LAST   = K_WIDTH'(KEEP_BINS - 1);
   state_t state;
   logic [CNT_W-1:0] cnt;
   logic in_stream, at_last, keep0, err0;
   logic s1_keep, s1_err, s2_keep, s2_err, done_q, err_q;
   logic signed [IN_WIDTH-1:0] s1_re, s1_im;
   logic [K_WIDTH-1:0] s1_tag, s2_tag, k_q;
   assign in_stream = state == STREAM;
   assign at_last   = cnt == CNT_LAST;
   assign keep0     = bus.fft_valid_in && in_stream && ({1'b0, cnt} < KEEP_LIM);
   // a last flag off the final slot, or the final slot without one, both mean misalignment
   assign err0      = bus.fft_valid_in && in_stream && (bus.fft_last_in != at_last);
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state   <= UNSYNCED;
         cnt     <= '0;
         s1_keep <= 1'b0;
         s1_err  <= 1'b0;
         s2_keep <= 1'b0;
         s2_err  <= 1'b0;
         k_q     <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (bus.fft_valid_in && !in_stream && bus.fft_last_in) begin
            state <= STREAM;
            cnt   <= '0;
         end else if (bus.fft_valid_in && in_stream)
            cnt <= (bus.fft_last_in || at_last) ? '0 : cnt + 1'b1;
         s1_keep <= keep0;
         s1_err  <= err0;
         s1_re   <= bus.fft_re_in;
         s1_im   <= bus.fft_im_in;
         s1_tag  <= cnt[K_WIDTH-1:0];
         s2_keep <= s1_keep;
         s2_err  <= s1_err;
         s2_tag  <= s1_tag;
         if (s2_keep) k_q <= s2_tag;
         done_q  <= s2_keep && s2_tag == K_LAST;
         err_q   <= s2_err;
      end
   end
   complex_mag_sq #(.IN_WIDTH(IN_WIDTH), .POWER_WIDTH(POWER_WIDTH)) u_mag (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .in_valid  (s1_keep),
      .re        (s1_re),
      .im        (s1_im),
      .out_valid (bus.power_valid_out),
      .power     (bus.power_out)
   );
   assign bus.k_out           = k_q;
   assign bus.frame_done_out  = done_q;
   assign bus.frame_error_out = err_q;
   assign bus.synced_out      = in_stream;
endmodule

// File: tb/tb_fft_power_streamer.sv
// tb_fft_power_streamer: random frames checked every cycle against a slot-scheduled bin model
module tb_fft_power_streamer;
   localparam int N = 1024;
   localparam int KEEP = 512;
   typedef struct {
      bit          v;
      logic [31:0] p;
      int          k;
      bit          done;
      bit          err;
      bit          sync;
      bit          krst;
   } exp_t;
   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   fft_power_streamer_if bus();
   fft_power_streamer dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));
   always #5 clk_in = ~clk_in;
   exp_t slots[8];
   int cyc = 0, n_tests = 0, n_fail = 0, exp_k = 0, m_idx = 0;
   bit chk = 1'b0, m_sync = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic signed [15:0] rnd();
      return 16'($urandom);
   endfunction

   // drive one cycle and schedule what the outputs must show 3 cycles (reset: 1 cycle) later
   task automatic step(input bit r, input bit v, input bit l, input logic signed [15:0] re, input logic signed [15:0] im);
      exp_t e;
      rst_in = r;
      bus.fft_valid_in = v;
      bus.fft_last_in = l;
      bus.fft_re_in = re;
      bus.fft_im_in = im;
      e = '{default: 0};
      if (r) begin
         m_sync = 0;
         m_idx = 0;
         for (int d = 1; d <= 3; d++) slots[(cyc + d) % 8] = e;
         slots[(cyc + 1) % 8].krst = 1;
      end else begin
         if (v && m_sync) begin
            e.err = l != (m_idx == N - 1);
            if (m_idx < KEEP) begin
               e.v = 1;
               e.p = 32'(longint'(re) * re + longint'(im) * im);
               e.k = m_idx;
               e.done = m_idx == KEEP - 1;
            end
            m_idx = (l || m_idx == N - 1) ? 0 : m_idx + 1;
         end else if (v && l) begin
            m_sync = 1;
            m_idx = 0;
         end
         slots[(cyc + 3) % 8] = e;
      end
      slots[(cyc + 1) % 8].sync = m_sync;
      @(posedge clk_in);
      #1;
      cyc++;
   endtask

   // mode 0: random, 1: re=3 im=-4, 2: random with bin 7 at full negative scale
   task automatic run(input int from, input int to, input int last_at, input int gap, input int mode);
      for (int i = from; i < to; i++) begin
         logic signed [15:0] re, im;
         if (gap == 1 || (gap == 2 && $urandom_range(2) == 0)) step(0, 0, 0, rnd(), rnd());
         re = mode == 1 ? 16'sd3 : (mode == 2 && i == 7) ? 16'sh8000 : rnd();
         im = mode == 1 ? -16'sd4 : (mode == 2 && i == 7) ? 16'sh8000 : rnd();
         step(0, 1, i == last_at, re, im);
      end
   endtask

   always @(negedge clk_in) begin
      exp_t e;
      e = slots[cyc % 8];
      if (chk) begin
         if (e.krst) exp_k = 0;
         if (e.v) exp_k = e.k;
         check("power_valid", bus.power_valid_out, e.v);
         check("power", bus.power_out, e.p);
         check("k", bus.k_out, exp_k);
         check("frame_done", bus.frame_done_out, e.done);
         check("frame_error", bus.frame_error_out, e.err);
         check("synced", bus.synced_out, e.sync);
      end
   end

   initial begin
      bus.fft_valid_in = 0;
      bus.fft_last_in = 0;
      bus.fft_re_in = 0;
      bus.fft_im_in = 0;
      repeat (3) step(1, 0, 0, 0, 0);
      chk = 1;
      check("reset_power", bus.power_out, 0);
      check("reset_synced", bus.synced_out, 0);
      run(0, 1023, -1, 0, 0);
      check("synced_before_last", bus.synced_out, 0);
      run(1023, 1024, 1023, 0, 0);
      check("synced_after_last", bus.synced_out, 1);
      run(0, 3, 1023, 0, 1);
      check("first_valid", bus.power_valid_out, 1);
      check("first_power", bus.power_out, 25);
      check("first_k", bus.k_out, 0);
      run(3, 514, 1023, 0, 1);
      check("done_k", bus.k_out, 511);
      check("done_pulse", bus.frame_done_out, 1);
      run(514, 516, 1023, 0, 1);
      check("quiet_power", bus.power_out, 0);
      check("quiet_valid", bus.power_valid_out, 0);
      run(516, 1024, 1023, 0, 1);
      run(0, 10, 1023, 0, 2);
      check("extreme_power", bus.power_out, 64'h8000_0000);
      check("extreme_k", bus.k_out, 7);
      run(10, 1024, 1023, 0, 2);
      run(0, 1024, 1023, 1, 0);
      run(0, 603, 600, 0, 0);
      check("early_last_err", bus.frame_error_out, 1);
      run(603, 604, -1, 0, 0);
      check("resync_k", bus.k_out, 0);
      check("resync_valid", bus.power_valid_out, 1);
      run(604, 601 + N, 601 + N - 1, 0, 0);
      run(0, 1024, 1023, 2, 0);
      run(0, 1024, -1, 0, 0);
      run(0, 2, 1023, 0, 0);
      check("missing_last_err", bus.frame_error_out, 1);
      run(2, 3, 1023, 0, 0);
      check("after_missing_k", bus.k_out, 0);
      check("after_missing_valid", bus.power_valid_out, 1);
      run(3, 1024, 1023, 0, 0);
      run(0, 203, 1023, 0, 0);
      check("mid_k", bus.k_out, 200);
      step(1, 1, 0, rnd(), rnd());
      check("rst_valid", bus.power_valid_out, 0);
      check("rst_power", bus.power_out, 0);
      check("rst_k", bus.k_out, 0);
      check("rst_synced", bus.synced_out, 0);
      run(0, 20, -1, 0, 0);
      check("unsynced_after_rst", bus.synced_out, 0);
      run(20, 21, 20, 0, 0);
      run(0, 1024, 1023, 0, 0);
      repeat (6) step(0, 0, 0, 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
